// File: rtl/subtractor_seq.sv
// Chunk-serial add/subtract: CHUNK bits per clock, LSB chunk first, with a registered inter-chunk carry.
// Define SUBTRACTOR_SEQ_OVF_EN to build the signed-overflow flag; otherwise Overflow_out is tied low.
module subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk_in,
    input  logic             Reset_in,
    input  logic             Start_in,
    input  logic             Mode_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Carry_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic [WIDTH-1:0] Result_out,
    output logic             Carry_out,
    output logic             Overflow_out
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // effective operand: ~B for subtract, B for add
    logic             carry_q;
    logic [IDXW-1:0]  idx;
    logic [CHUNK:0]   sum;

    always_comb begin
        sum = {1'b0, a_q[idx*CHUNK +: CHUNK]} + {1'b0, b_q[idx*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry_q};
    end

    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx        <= '0;
            Busy_out   <= 1'b0;
            Done_out   <= 1'b0;
            Result_out <= '0;
            Carry_out  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done_out <= 1'b0;
                    if (Start_in) begin
                        a_q        <= A_in;
                        b_q        <= Mode_in ? B_in : ~B_in;
                        carry_q    <= Carry_in;
                        idx        <= '0;
                        Result_out <= '0;
                        Busy_out   <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    Result_out[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry_q <= sum[CHUNK];
                    if (idx == LAST) begin
                        Carry_out <= sum[CHUNK];
                        Busy_out  <= 1'b0;
                        Done_out  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SUBTRACTOR_SEQ_OVF_EN
    logic ovf_q;

    // The final result MSB is the top bit of the last chunk's sum, written on this same edge.
    always_ff @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && idx == LAST) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
        end
    end

    assign Overflow_out = ovf_q;
`else
    assign Overflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_subtractor_seq.sv
// Bench for subtractor_seq (WIDTH=16, CHUNK=4): arithmetic model checked every cycle plus directed literal cases.
module tb_subtractor_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
`ifdef SUBTRACTOR_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             Clk_in = 1'b0;
    logic             Reset_in = 1'b0;
    logic             Start_in = 1'b0;
    logic             Mode_in = 1'b0;
    logic [WIDTH-1:0] A_in = '0;
    logic [WIDTH-1:0] B_in = '0;
    logic             Carry_in = 1'b0;
    logic             Busy_out;
    logic             Done_out;
    logic [WIDTH-1:0] Result_out;
    logic             Carry_out;
    logic             Overflow_out;

    subtractor_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .Clk_in(Clk_in), .Reset_in(Reset_in), .Start_in(Start_in), .Mode_in(Mode_in),
        .A_in(A_in), .B_in(B_in), .Carry_in(Carry_in),
        .Busy_out(Busy_out), .Done_out(Done_out), .Result_out(Result_out),
        .Carry_out(Carry_out), .Overflow_out(Overflow_out)
    );

    always #5 Clk_in = ~Clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit check_en = 1'b0;

    always @(posedge Clk_in) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: full-width sum computed once at acceptance; k edges into the operation the low k chunks are visible.
    bit          m_active = 0;
    int          m_k = 0;
    logic [16:0] m_full = '0;
    logic [15:0] m_a = '0;
    logic [15:0] m_beff = '0;
    logic [15:0] m_res = '0;
    logic        m_done = 0;
    logic        m_cout = 0;
    logic        m_ovf = 0;

    always @(posedge Clk_in or posedge Reset_in) begin
        if (Reset_in) begin
            m_active = 0; m_k = 0; m_res = '0; m_done = 0; m_cout = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_active) begin
                m_k++;
                m_res = (m_k >= N) ? m_full[15:0] : m_full[15:0] & 16'((32'd1 << (m_k * CHUNK)) - 1);
                if (m_k == N) begin
                    m_active = 0;
                    m_done   = 1;
                    m_cout   = m_full[16];
                    m_ovf    = OVF_ON && (m_a[15] == m_beff[15]) && (m_full[15] != m_a[15]);
                end
            end else if (Start_in) begin
                m_a      = A_in;
                m_beff   = Mode_in ? B_in : ~B_in;
                m_full   = {1'b0, m_a} + {1'b0, m_beff} + 17'(Carry_in);
                m_active = 1;
                m_k      = 0;
                m_res    = '0;
            end
        end
    end

    always @(negedge Clk_in) begin
        if (check_en) begin
            check("busy", 32'(Busy_out), 32'(m_active));
            check("done", 32'(Done_out), 32'(m_done));
            check("result", 32'(Result_out), 32'(m_res));
            check("carry", 32'(Carry_out), 32'(m_cout));
            check("overflow", 32'(Overflow_out), 32'(m_ovf));
        end
    end

    int start_cyc = 0;

    // Called at posedge+2; the operation is accepted on the next rising edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic mode, input logic cin);
        A_in = a; B_in = b; Mode_in = mode; Carry_in = cin; Start_in = 1'b1;
        @(posedge Clk_in);
        #2;
        start_cyc = cyc;
        Start_in = 1'b0;
    endtask

    // lat = edges from the acceptance edge to the edge that samples Done_out high.
    task automatic wait_done(input string name, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk_in);
            if (Busy_out === 1'b1) busy_n++;
            if (Done_out === 1'b1) begin
                lat = cyc - start_cyc + 1;
                break;
            end
        end
        if (lat < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic mode, input logic cin,
                          input logic [15:0] er, input logic ec, input logic eo);
        int lat, bn;
        start_op(a, b, mode, cin);
        wait_done(name, lat, bn);
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_busy_cycles"}, 32'(bn), 32'd4);
        check({name, "_res"}, 32'(Result_out), 32'(er));
        check({name, "_cout"}, 32'(Carry_out), 32'(ec));
        check({name, "_ovf"}, 32'(Overflow_out), 32'(eo));
        @(posedge Clk_in);
        #2;
    endtask

    initial begin
        int lat, bn, prev;
        #1 Reset_in = 1'b1;
        repeat (2) @(posedge Clk_in);
        #2;
        check("rst_busy", 32'(Busy_out), 32'd0);
        check("rst_done", 32'(Done_out), 32'd0);
        check("rst_result", 32'(Result_out), 32'd0);
        check("rst_carry", 32'(Carry_out), 32'd0);
        check("rst_ovf", 32'(Overflow_out), 32'd0);
        check_en = 1'b1;
        Reset_in = 1'b0;

        run_op("sub_basic", 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
        run_op("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b0, OVF_ON);

        // Start pulse with new operands 2 cycles into RUN must be ignored
        start_op(16'h1234, 16'h0234, 1'b0, 1'b1);
        repeat (2) @(posedge Clk_in);
        #2;
        A_in = 16'hFFFF; B_in = 16'h0001; Mode_in = 1'b1; Carry_in = 1'b0; Start_in = 1'b1;
        @(posedge Clk_in);
        #2 Start_in = 1'b0;
        wait_done("ignore", lat, bn);
        check("ignore_latency", 32'(lat), 32'd5);
        check("ignore_res", 32'(Result_out), 32'h1000);
        check("ignore_cout", 32'(Carry_out), 32'd1);
        repeat (3) @(posedge Clk_in);
        #2;

        // Asynchronous reset mid-operation, then a fresh start on the first edge after release
        start_op(16'hABCD, 16'h1111, 1'b1, 1'b0);
        repeat (2) @(posedge Clk_in);
        #3 Reset_in = 1'b1;
        #1;
        check("arst_busy", 32'(Busy_out), 32'd0);
        check("arst_done", 32'(Done_out), 32'd0);
        check("arst_result", 32'(Result_out), 32'd0);
        check("arst_carry", 32'(Carry_out), 32'd0);
        check("arst_ovf", 32'(Overflow_out), 32'd0);
        @(posedge Clk_in);
        #2 Reset_in = 1'b0;
        run_op("post_rst", 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);

        // Start held high: three operations back to back, operands changed right after each acceptance
        A_in = 16'h0005; B_in = 16'h0003; Mode_in = 1'b0; Carry_in = 1'b1; Start_in = 1'b1;
        @(posedge Clk_in);
        #2 start_cyc = cyc;
        A_in = 16'h1111; B_in = 16'h2222; Mode_in = 1'b1; Carry_in = 1'b1;
        wait_done("b2b0", lat, bn);
        check("b2b0_latency", 32'(lat), 32'd5);
        check("b2b0_res", 32'(Result_out), 32'h0002);
        check("b2b0_cout", 32'(Carry_out), 32'd1);
        prev = cyc;
        @(posedge Clk_in);
        #2 start_cyc = cyc;
        A_in = 16'h0100; B_in = 16'h0200; Mode_in = 1'b0; Carry_in = 1'b1;
        wait_done("b2b1", lat, bn);
        check("b2b1_spacing", 32'(cyc - prev), 32'd5);
        check("b2b1_res", 32'(Result_out), 32'h3334);
        check("b2b1_cout", 32'(Carry_out), 32'd0);
        prev = cyc;
        @(posedge Clk_in);
        #2 start_cyc = cyc;
        Start_in = 1'b0;
        wait_done("b2b2", lat, bn);
        check("b2b2_spacing", 32'(cyc - prev), 32'd5);
        check("b2b2_res", 32'(Result_out), 32'hFF00);
        check("b2b2_cout", 32'(Carry_out), 32'd0);
        repeat (3) @(posedge Clk_in);
        #2;

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
